// File: rtl/fwd_learn_engine.sv
// Learning forwarder: CAM lookup, oldest-entry replacement, aging, flush; FWD_STATS_EN adds class counters.
// Requests appear 1 cycle after acceptance; ready_o stays low until every requested VOQ has handshaken.
module fwd_learn_engine #(
   parameter int NUM_PORTS       = 4,
   parameter int ADDR_W          = 12,
   parameter int TABLE_DEPTH     = 16,
   parameter int AGE_W           = 4,
   parameter int AGE_TICK_CYCLES = 1024
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             eof_i,
   output logic                             ready_o,
   input  logic [$clog2(NUM_PORTS)-1:0]     ingress_port_i,
   input  logic [47:0]                      rx_mac_src_addr_i,
   input  logic [47:0]                      rx_mac_dst_addr_i,
   input  logic [ADDR_W-1:0]                data_start_ptr_i,
   input  logic                             flush_i,
   input  logic [NUM_PORTS-1:0]             voq_ready_i,
   output logic [NUM_PORTS-1:0]             voq_write_reqs_o,
   output logic [ADDR_W-1:0]                voq_start_ptrs_o [NUM_PORTS],
   output logic [$clog2(TABLE_DEPTH):0]     table_count_o
`ifdef FWD_STATS_EN
  ,output logic [15:0]                      flood_cnt_o,
   output logic [15:0]                      filter_cnt_o,
   output logic [15:0]                      hit_cnt_o
`endif
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam int IW = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
   localparam int CW = $clog2(TABLE_DEPTH) + 1;
   localparam int TW = (AGE_TICK_CYCLES > 1) ? $clog2(AGE_TICK_CYCLES) : 1;
   localparam logic [AGE_W-1:0] AGE_LAST = {{(AGE_W-1){1'b1}}, 1'b0};
   localparam logic [NUM_PORTS-1:0] ONE_HOT0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [NUM_PORTS-1:0] reqs_q, reqs_d;
   logic [ADDR_W-1:0]    ptrs_q [NUM_PORTS];
   logic [ADDR_W-1:0]    ptrs_d [NUM_PORTS];
   logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
   logic [CW-1:0]        count_q, count_d;

   logic                 valid_q [TABLE_DEPTH];
   logic                 valid_d [TABLE_DEPTH];
   logic [47:0]          mac_q   [TABLE_DEPTH];
   logic [47:0]          mac_d   [TABLE_DEPTH];
   logic [PW-1:0]        port_q  [TABLE_DEPTH];
   logic [PW-1:0]        port_d  [TABLE_DEPTH];
   logic [AGE_W-1:0]     age_q   [TABLE_DEPTH];
   logic [AGE_W-1:0]     age_d   [TABLE_DEPTH];

   logic                 accept, tick, learn_en;
   logic                 dst_hit, src_hit, full;
   logic [PW-1:0]        dst_port;
   logic [IW-1:0]        src_idx, free_idx, old_idx, learn_idx;
   logic [AGE_W-1:0]     old_age;
   logic                 is_flood, is_filter;
   logic [NUM_PORTS-1:0] in_oh, mask;

   assign accept   = eof_i && (state_q == ST_IDLE);
   assign tick     = (tick_cnt_q == TW'(AGE_TICK_CYCLES - 1));
   assign learn_en = accept && !rx_mac_src_addr_i[40];

   // All lookups below read the pre-edge table, so dst never sees this frame's learn.
   always_comb begin
      dst_hit  = 1'b0;
      dst_port = '0;
      src_hit  = 1'b0;
      src_idx  = '0;
      full     = 1'b1;
      free_idx = '0;
      old_idx  = '0;
      old_age  = '0;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
         if (valid_q[i] && (mac_q[i] == rx_mac_dst_addr_i) && !dst_hit) begin
            dst_hit  = 1'b1;
            dst_port = port_q[i];
         end
         if (valid_q[i] && (mac_q[i] == rx_mac_src_addr_i) && !src_hit) begin
            src_hit = 1'b1;
            src_idx = IW'(i);
         end
         if (age_q[i] > old_age) begin
            old_age = age_q[i];
            old_idx = IW'(i);
         end
      end
      for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            full     = 1'b0;
            free_idx = IW'(i);
         end
      end
   end

   always_comb begin
      in_oh     = ONE_HOT0 << ingress_port_i;
      is_flood  = rx_mac_dst_addr_i[40] || !dst_hit;
      is_filter = !is_flood && (dst_port == ingress_port_i);
      if (is_flood)
         mask = ~in_oh;
      else if (is_filter)
         mask = '0;
      else
         mask = ONE_HOT0 << dst_port;
      learn_idx = src_hit ? src_idx : (full ? old_idx : free_idx);
   end

   // Priority per entry: flush, then learn, then aging tick.
   always_comb begin
      count_d = '0;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
         valid_d[i] = valid_q[i];
         mac_d[i]   = mac_q[i];
         port_d[i]  = port_q[i];
         age_d[i]   = age_q[i];
         if (flush_i) begin
            valid_d[i] = 1'b0;
            age_d[i]   = '0;
         end else if (learn_en && (learn_idx == IW'(i))) begin
            valid_d[i] = 1'b1;
            mac_d[i]   = rx_mac_src_addr_i;
            port_d[i]  = ingress_port_i;
            age_d[i]   = '0;
         end else if (tick && valid_q[i]) begin
            if (age_q[i] == AGE_LAST) begin
               valid_d[i] = 1'b0;
               age_d[i]   = '0;
            end else begin
               age_d[i] = age_q[i] + 1'b1;
            end
         end
         count_d = count_d + CW'(valid_d[i]);
      end
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      reqs_d  = reqs_q;
      for (int p = 0; p < NUM_PORTS; p++) ptrs_d[p] = ptrs_q[p];
      if (state_q == ST_IDLE) begin
         if (accept && (mask != '0)) begin
            reqs_d  = mask;
            state_d = ST_ISSUE;
            for (int p = 0; p < NUM_PORTS; p++) ptrs_d[p] = data_start_ptr_i;
         end
      end else begin
         reqs_d = reqs_q & ~voq_ready_i;
         if (reqs_d == '0) state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         reqs_q     <= '0;
         tick_cnt_q <= '0;
         count_q    <= '0;
         for (int p = 0; p < NUM_PORTS; p++) ptrs_q[p] <= '0;
         for (int i = 0; i < TABLE_DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            mac_q[i]   <= '0;
            port_q[i]  <= '0;
            age_q[i]   <= '0;
         end
      end else begin
         state_q    <= state_d;
         reqs_q     <= reqs_d;
         tick_cnt_q <= tick_cnt_d;
         count_q    <= count_d;
         for (int p = 0; p < NUM_PORTS; p++) ptrs_q[p] <= ptrs_d[p];
         for (int i = 0; i < TABLE_DEPTH; i++) begin
            valid_q[i] <= valid_d[i];
            mac_q[i]   <= mac_d[i];
            port_q[i]  <= port_d[i];
            age_q[i]   <= age_d[i];
         end
      end
   end

   assign ready_o          = (state_q == ST_IDLE);
   assign voq_write_reqs_o = reqs_q;
   assign voq_start_ptrs_o = ptrs_q;
   assign table_count_o    = count_q;

`ifdef FWD_STATS_EN
   logic [15:0] flood_cnt_q, filter_cnt_q, hit_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flood_cnt_q  <= '0;
         filter_cnt_q <= '0;
         hit_cnt_q    <= '0;
      end else if (accept) begin
         if (is_flood && (flood_cnt_q != 16'hFFFF))
            flood_cnt_q <= flood_cnt_q + 16'd1;
         if (is_filter && (filter_cnt_q != 16'hFFFF))
            filter_cnt_q <= filter_cnt_q + 16'd1;
         if (!is_flood && !is_filter && (hit_cnt_q != 16'hFFFF))
            hit_cnt_q <= hit_cnt_q + 16'd1;
      end
   end

   assign flood_cnt_o  = flood_cnt_q;
   assign filter_cnt_o = filter_cnt_q;
   assign hit_cnt_o    = hit_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_learn_engine.sv
// Directed bench for fwd_learn_engine with a 4-entry table, 2-bit ages and a 16-cycle aging tick.
module tb_fwd_learn_engine;

   localparam int NP = 4;
   localparam int AW = 12;
   localparam int TD = 4;
   localparam int CW = 3;

   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] MCSRC = 48'h0100_0000_0077;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           eof_i = 1'b0;
   logic           ready_o;
   logic [1:0]     ingress_port_i = '0;
   logic [47:0]    rx_mac_src_addr_i = '0;
   logic [47:0]    rx_mac_dst_addr_i = '0;
   logic [AW-1:0]  data_start_ptr_i = '0;
   logic           flush_i = 1'b0;
   logic [NP-1:0]  voq_ready_i = '1;
   logic [NP-1:0]  voq_write_reqs_o;
   logic [AW-1:0]  voq_start_ptrs_o [NP];
   logic [CW-1:0]  table_count_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fwd_learn_engine #(
      .NUM_PORTS(NP), .ADDR_W(AW), .TABLE_DEPTH(TD), .AGE_W(2), .AGE_TICK_CYCLES(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .eof_i(eof_i), .ready_o(ready_o),
      .ingress_port_i(ingress_port_i), .rx_mac_src_addr_i(rx_mac_src_addr_i),
      .rx_mac_dst_addr_i(rx_mac_dst_addr_i), .data_start_ptr_i(data_start_ptr_i),
      .flush_i(flush_i), .voq_ready_i(voq_ready_i), .voq_write_reqs_o(voq_write_reqs_o),
      .voq_start_ptrs_o(voq_start_ptrs_o), .table_count_o(table_count_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reset released on a negedge so the following posedge is cycle 1 of the aging counter.
   task automatic do_reset();
      eof_i       = 1'b0;
      flush_i     = 1'b0;
      voq_ready_i = '1;
      rst_n       = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send(input logic [1:0] ing, input logic [47:0] src, input logic [47:0] dst,
                       input logic [AW-1:0] ptr, input logic fl);
      ingress_port_i    = ing;
      rx_mac_src_addr_i = src;
      rx_mac_dst_addr_i = dst;
      data_start_ptr_i  = ptr;
      flush_i           = fl;
      eof_i             = 1'b1;
      @(posedge clk);
      #1;
      eof_i   = 1'b0;
      flush_i = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Basic flood, unicast with backpressure, same-port filter.
      do_reset();
      check("rst_ready", 64'(ready_o), 64'd1);
      check("rst_reqs", 64'(voq_write_reqs_o), 64'd0);
      check("rst_count", 64'(table_count_o), 64'd0);
      for (int p = 0; p < NP; p++) check("rst_ptr", 64'(voq_start_ptrs_o[p]), 64'd0);

      send(2'd0, 48'h1, 48'hAA, 12'h010, 1'b0);
      check("flood_reqs", 64'(voq_write_reqs_o), 64'hE);
      for (int p = 0; p < NP; p++) check("flood_ptr", 64'(voq_start_ptrs_o[p]), 64'h010);
      check("flood_count", 64'(table_count_o), 64'd1);
      check("flood_busy", 64'(ready_o), 64'd0);
      next_cycle();
      check("flood_done_reqs", 64'(voq_write_reqs_o), 64'd0);
      check("flood_done_ready", 64'(ready_o), 64'd1);

      voq_ready_i = 4'b1110;
      send(2'd1, 48'h2, 48'h1, 12'h020, 1'b0);
      check("uc_reqs", 64'(voq_write_reqs_o), 64'h1);
      check("uc_ptr0", 64'(voq_start_ptrs_o[0]), 64'h020);
      check("uc_count", 64'(table_count_o), 64'd2);
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         check("bp_reqs", 64'(voq_write_reqs_o), 64'h1);
         check("bp_ready", 64'(ready_o), 64'd0);
      end
      voq_ready_i = '1;
      next_cycle();
      check("bp_done_reqs", 64'(voq_write_reqs_o), 64'd0);
      check("bp_done_ready", 64'(ready_o), 64'd1);

      send(2'd0, 48'h3, 48'h1, 12'h030, 1'b0);
      check("filt_reqs", 64'(voq_write_reqs_o), 64'd0);
      check("filt_ready", 64'(ready_o), 64'd1);
      check("filt_count", 64'(table_count_o), 64'd3);

      // Five learns before the first tick: all ages 0, so entry 0 (MAC 01) is replaced.
      do_reset();
      send(2'd1, 48'h1, BCAST, 12'h101, 1'b0); next_cycle();
      send(2'd2, 48'h2, BCAST, 12'h102, 1'b0); next_cycle();
      send(2'd3, 48'h3, BCAST, 12'h103, 1'b0); next_cycle();
      send(2'd0, 48'h4, BCAST, 12'h104, 1'b0); next_cycle();
      check("full_count", 64'(table_count_o), 64'd4);
      send(2'd0, 48'h5, BCAST, 12'h105, 1'b0); next_cycle();
      check("evict_count", 64'(table_count_o), 64'd4);
      send(2'd3, MCSRC, 48'h1, 12'h200, 1'b0);
      check("evicted_floods", 64'(voq_write_reqs_o), 64'h7);
      next_cycle();
      send(2'd3, MCSRC, 48'h5, 12'h201, 1'b0);
      check("new_entry_hit", 64'(voq_write_reqs_o), 64'h1);
      next_cycle();
      send(2'd3, MCSRC, 48'h2, 12'h202, 1'b0);
      check("kept_entry_hit", 64'(voq_write_reqs_o), 64'h4);
      check("mcsrc_no_learn", 64'(table_count_o), 64'd4);
      next_cycle();

      // Aging: ticks at cycles 16, 32, 48; the third invalidates the entry.
      do_reset();
      send(2'd1, 48'hA, BCAST, 12'h300, 1'b0);
      check("age_learn_reqs", 64'(voq_write_reqs_o), 64'hD);
      next_cycle();
      repeat (45) @(posedge clk);
      #1;
      check("age_before_expiry", 64'(table_count_o), 64'd1);
      next_cycle();
      check("age_expired", 64'(table_count_o), 64'd0);
      send(2'd0, MCSRC, 48'hA, 12'h301, 1'b0);
      check("aged_floods", 64'(voq_write_reqs_o), 64'hE);
      next_cycle();
      send(2'd2, MCSRC, BCAST, 12'h302, 1'b0);
      check("bcast_reqs", 64'(voq_write_reqs_o), 64'hB);
      for (int p = 0; p < NP; p++) check("bcast_ptr", 64'(voq_start_ptrs_o[p]), 64'h302);
      next_cycle();

      // Flush with a same-edge learn; lookup still sees the pre-flush table.
      do_reset();
      send(2'd1, 48'h1, BCAST, 12'h400, 1'b0);
      next_cycle();
      check("pre_flush_count", 64'(table_count_o), 64'd1);
      voq_ready_i = 4'b1101;
      send(2'd0, 48'h2, 48'h1, 12'h401, 1'b1);
      check("flush_lookup_reqs", 64'(voq_write_reqs_o), 64'h2);
      check("flush_count", 64'(table_count_o), 64'd0);
      check("flush_issue", 64'(ready_o), 64'd0);
      next_cycle();
      check("flush_req_held", 64'(voq_write_reqs_o), 64'h2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_reqs", 64'(voq_write_reqs_o), 64'd0);
      check("async_rst_ready", 64'(ready_o), 64'd1);
      @(negedge clk);
      rst_n       = 1'b1;
      voq_ready_i = '1;
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fwd_learn_engine.md
Name: fwd_learn_engine

Overview:
- Parametrised successor to the single-table learning crossbar.
- Takes one end-of-frame descriptor per frame from the ingress arbiter and looks up the destination MAC in a fully associative learning table.
- Issues per-port VOQ write requests, with backpressure, carrying the frame start pointer.
- Adds replacement of the oldest entry when the table is full, periodic aging, flood that excludes the ingress port, same-port filtering, and table flush.

Parameters:
- NUM_PORTS, 4, number of switch ports; must be >= 2.
- ADDR_W, 12, width of the packet-buffer start pointer.
- TABLE_DEPTH, 16, number of learning-table entries.
- AGE_W, 4, width of the per-entry age counter.
- AGE_TICK_CYCLES, 1024, clock cycles between aging ticks.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- eof_i  in  1  frame descriptor valid.
- ready_o  out  1  engine can accept a descriptor.
- ingress_port_i  in  $clog2(NUM_PORTS)  port the frame arrived on.
- rx_mac_src_addr_i  in  48  source MAC.
- rx_mac_dst_addr_i  in  48  destination MAC.
- data_start_ptr_i  in  ADDR_W  frame start address in the buffer.
- flush_i  in  1  invalidate all table entries.
- voq_ready_i  in  NUM_PORTS  VOQ p can take a write this cycle.
- voq_write_reqs_o  out  NUM_PORTS  per-port write request.
- voq_start_ptrs_o  out  ADDR_W x NUM_PORTS  start pointer per port; unpacked array.
- table_count_o  out  $clog2(TABLE_DEPTH)+1  number of valid entries.

Behaviour:
- Reset (async, rst_n=0):
  - All entries invalid, ages 0, aging counter 0, FSM in IDLE.
  - ready_o=1, voq_write_reqs_o=0, voq_start_ptrs_o all 0, table_count_o=0.
- FSM states: IDLE and ISSUE.
  - ready_o=1 only in IDLE.
  - A descriptor is accepted on a posedge where eof_i=1 and state is IDLE.
  - eof_i is ignored in ISSUE; the upstream arbiter holds it.
- Lookup uses the table state before this frame's learning update, i.e. the dst lookup sees the pre-learn table.
  - dst[40]=1 (multicast/broadcast) or dst miss: flood. Mask = all ports except ingress_port_i.
  - dst hit on port P with P != ingress: mask = one-hot P.
  - dst hit with P == ingress: filter. Mask = 0 and no request is issued; FSM stays in IDLE.
- Output latency:
  - Accepted at edge T with a nonzero mask: at T+1, voq_write_reqs_o = mask, every voq_start_ptrs_o[p] = data_start_ptr_i, and state = ISSUE.
- ISSUE handshake:
  - Bit p retires on an edge where voq_write_reqs_o[p] && voq_ready_i[p]; that bit then clears.
  - The remaining bits and the pointers hold.
  - When the last bit retires, the next state is IDLE and voq_write_reqs_o becomes 0.
  - Minimum spacing between accepted frames is 2 cycles.
- Learning (on the acceptance edge, only when src[40]=0):
  - src hit: update the entry's port and set its age to 0.
  - src miss, table not full: write into the lowest-index invalid entry with age 0.
  - src miss, table full: replace the entry with the largest age; ties go to the lowest index.
- Aging:
  - A free-running counter wraps at AGE_TICK_CYCLES-1. On the wrap edge, every valid entry's age increments.
  - An entry whose age would reach 2^AGE_W-1 is invalidated instead.
  - A learn and a tick on the same entry in the same cycle: the learn wins (age=0).
- Flush:
  - flush_i=1 invalidates every entry on that edge; it overrides a same-cycle learn or tick.
  - A lookup in the same cycle still uses the pre-flush state.
  - Pending ISSUE requests are unaffected.
- table_count_o is registered and reflects the post-edge table.
- Reset asserted mid-ISSUE drops pending requests immediately (asynchronous clear).

Optional Feature:
- Macro FWD_STATS_EN.
- When defined, the block adds outputs flood_cnt_o, filter_cnt_o and hit_cnt_o.
  - Each is 16 bits, saturating at 16'hFFFF, and cleared by reset.
  - Each increments once per accepted descriptor of its class.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan (NUM_PORTS=4, TABLE_DEPTH=4, AGE_W=2, AGE_TICK_CYCLES=16):
- src=...01, dst=...AA, ptr=12'h010, ingress=0 -> at T+1 reqs=4'b1110, all ptrs=12'h010; table_count_o=1.
- Then src=...02, dst=...01, ptr=12'h020, ingress=1 -> reqs=4'b0001, ptr[0]=12'h020; voq_ready_i[0] held low 3 cycles -> reqs held and ready_o=0 until the handshake.
- src=...03, dst=...01, ingress=0 -> filter: reqs stay 0, ready_o stays 1, table_count_o=3.
- Learn 5 distinct sources with no traffic in between -> the fifth evicts the oldest entry (MAC ...01); a lookup of dst=...01 then floods.
- Idle for 48 cycles after learning -> the entry is invalidated at the third tick and table_count_o=0; dst=FF:FF:FF:FF:FF:FF on ingress 2 -> reqs=4'b1011.
- Assert flush_i on the same edge as a new-src learn -> table_count_o=0; rst_n pulsed low while in ISSUE -> reqs=0 immediately and ready_o=1.
